// File: rtl/uart_rx.sv
// UART receiver: start bit, DATA_WIDTH data bits LSB-first, one stop bit.
// Received words appear on an AXI4-Stream master port. Bit period is prescale * 8 clocks.
module uart_rx #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    input  logic                  rxd,
    output logic                  busy,
    output logic                  overrun_error,
    output logic                  frame_error,
    input  logic [15:0]           prescale
);

    typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StBreak} state_e;

    state_e                state_q, state_d;
    logic                  rxd_meta_q, rxd_s_q;
    logic [15:0]           presc_q, presc_d;
    logic [18:0]           cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] sr_q, sr_d;
    logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
    logic [3:0]            idx_q, idx_d;
    logic                  tvalid_q, tvalid_d;
    logic                  ovr_q, ovr_d;
    logic                  ferr_q, ferr_d;

    logic [15:0]           presc_new;
    logic [18:0]           half_reload;
    logic [18:0]           bit_reload;
    logic                  tick;

    // Zero prescale behaves as one; the value is captured when the start edge is seen.
    assign presc_new   = (prescale == 16'd0) ? 16'd1 : prescale;
    assign half_reload = {1'b0, presc_new, 2'b00} - 19'd1;
    assign bit_reload  = {presc_q, 3'b000} - 19'd1;
    assign tick        = (cnt_q == 19'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rxd_meta_q <= 1'b1;
            rxd_s_q    <= 1'b1;
        end else begin
            rxd_meta_q <= rxd;
            rxd_s_q    <= rxd_meta_q;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = tick ? cnt_q : cnt_q - 19'd1;
        presc_d  = presc_q;
        sr_d     = sr_q;
        idx_d    = idx_q;
        tdata_d  = tdata_q;
        tvalid_d = tvalid_q && !m_axis_tready;
        ovr_d    = 1'b0;
        ferr_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (!rxd_s_q) begin
                    presc_d = presc_new;
                    cnt_d   = half_reload;
                    state_d = StStart;
                end
            end
            StStart: begin
                if (tick) begin
                    if (!rxd_s_q) begin
                        cnt_d   = bit_reload;
                        idx_d   = 4'd0;
                        state_d = StData;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            StData: begin
                if (tick) begin
                    sr_d  = {rxd_s_q, sr_q[DATA_WIDTH-1:1]};
                    cnt_d = bit_reload;
                    if (idx_q == 4'(DATA_WIDTH - 1)) begin
                        state_d = StStop;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            StStop: begin
                if (tick) begin
                    if (rxd_s_q) begin
                        // An unaccepted word is overwritten unless it is taken this same cycle.
                        tdata_d  = sr_q;
                        tvalid_d = 1'b1;
                        ovr_d    = tvalid_q && !m_axis_tready;
                        state_d  = StIdle;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = StBreak;
                    end
                end
            end
            StBreak: begin
                if (rxd_s_q) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            presc_q  <= 16'd1;
            cnt_q    <= 19'd0;
            sr_q     <= '0;
            idx_q    <= 4'd0;
            tdata_q  <= '0;
            tvalid_q <= 1'b0;
            ovr_q    <= 1'b0;
            ferr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            presc_q  <= presc_d;
            cnt_q    <= cnt_d;
            sr_q     <= sr_d;
            idx_q    <= idx_d;
            tdata_q  <= tdata_d;
            tvalid_q <= tvalid_d;
            ovr_q    <= ovr_d;
            ferr_q   <= ferr_d;
        end
    end

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign busy          = (state_q != StIdle);
    assign overrun_error = ovr_q;
    assign frame_error   = ferr_q;

endmodule
